sd_cmd_engine: RTL

Hardware sequencer for the SD card CMD line, replacing software bit-banging of command frames. It sits on the CPU peripheral bus and exposes argument, command, status, response and clock-divider registers. It generates SD_CLK, serialises 48-bit command frames with CRC7, waits for and captures 48-bit responses, and reports timeout and CRC errors. DAT lines are out of scope and remain with the existing bit-bang peripheral.

---
 rtl/sd_cmd_engine.sv | 248 ++++++++++++++++++++++++
 1 files changed

// File: rtl/sd_cmd_engine.sv
// SD card CMD-line sequencer: SD_CLK generation, 48-bit command framing with CRC7,
// response capture and status reporting behind a small register file.
module sd_cmd_engine #(
  parameter int CLK_DIV = 125,
  parameter int NCR_MAX = 64
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_request,
  input  logic        i_rw,
  input  logic [2:0]  i_address,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_ready,
  output logic        o_sd_clk,
  output logic        o_cmd_out,
  output logic        o_cmd_oe,
  input  logic        i_cmd_in
);

  typedef enum logic [2:0] {S_IDLE, S_SEND, S_WAIT, S_RECV, S_POST} state_t;

  localparam logic [15:0] DIV_RST  = 16'(CLK_DIV);
  localparam logic [15:0] NCR_LAST = 16'(NCR_MAX - 1);

  function automatic logic [6:0] crc7(input logic [39:0] d);
    logic [6:0] c;
    logic       fb;
    c = 7'd0;
    for (int i = 39; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  state_t      state_q, state_d;
  logic [47:0] sh_q, sh_d;
  logic [46:0] rx_q, rx_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] arg_q, arg_d;
  logic [15:0] div_q, div_d;
  logic        free_q, free_d;
  logic [31:0] resp_arg_q, resp_arg_d;
  logic [5:0]  resp_idx_q, resp_idx_d;
  logic        done_q, done_d;
  logic        to_q, to_d;
  logic        crc_err_q, crc_err_d;
  logic        end_err_q, end_err_d;
  logic        resp_en_q, resp_en_d;
  logic        ign_crc_q, ign_crc_d;
  logic [15:0] clk_cnt_q, clk_cnt_d;
  logic        sd_clk_q, sd_clk_d;
  logic        ready_q, ready_d;
  logic [31:0] rdata_q, rdata_d;

  logic        wr, rd, launch, busy;
  logic        run, tick, rise_tick, fall_tick;
  logic [15:0] lim;
  logic [47:0] rx_new;
  logic [39:0] tx_head;
  logic [31:0] rmux;
  logic        unused_wdata;

  assign unused_wdata = ^i_wdata[31:17];

  assign wr      = i_request && i_rw;
  assign rd      = i_request && !i_rw;
  assign busy    = (state_q != S_IDLE);
  assign launch  = wr && (i_address == 3'd1) && i_wdata[8] && !busy;
  assign tx_head = {2'b01, i_wdata[5:0], arg_q};
  assign rx_new  = {rx_q, i_cmd_in};

  // Clock generator: a zero divider behaves as one so SD_CLK never stalls.
  always_comb begin
    lim       = (div_q == 16'd0) ? 16'd1 : div_q;
    run       = busy || free_q;
    tick      = run && (clk_cnt_q >= lim - 16'd1);
    rise_tick = tick && !sd_clk_q;
    fall_tick = tick && sd_clk_q;
    clk_cnt_d = 16'd0;
    sd_clk_d  = 1'b0;
    if (run) begin
      clk_cnt_d = tick ? 16'd0 : clk_cnt_q + 16'd1;
      sd_clk_d  = tick ? ~sd_clk_q : sd_clk_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    sh_d       = sh_q;
    rx_d       = rx_q;
    cnt_d      = cnt_q;
    arg_d      = arg_q;
    div_d      = div_q;
    free_d     = free_q;
    resp_arg_d = resp_arg_q;
    resp_idx_d = resp_idx_q;
    done_d     = done_q;
    to_d       = to_q;
    crc_err_d  = crc_err_q;
    end_err_d  = end_err_q;
    resp_en_d  = resp_en_q;
    ign_crc_d  = ign_crc_q;

    if (wr && i_address == 3'd0) arg_d = i_wdata;
    if (wr && i_address == 3'd4 && !busy) begin
      div_d  = i_wdata[15:0];
      free_d = i_wdata[16];
    end

    case (state_q)
      S_IDLE: begin
        if (launch) begin
          state_d   = S_SEND;
          sh_d      = {tx_head, crc7(tx_head), 1'b1};
          cnt_d     = 16'd47;
          resp_en_d = i_wdata[6];
          ign_crc_d = i_wdata[7];
          done_d    = 1'b0;
          to_d      = 1'b0;
          crc_err_d = 1'b0;
          end_err_d = 1'b0;
        end
      end
      // cnt counts bits still to present; the extra fall after bit 0 closes the frame
      S_SEND: begin
        if (fall_tick) begin
          if (cnt_q == 16'd0) begin
            state_d = resp_en_q ? S_WAIT : S_POST;
          end else begin
            sh_d  = {sh_q[46:0], 1'b1};
            cnt_d = cnt_q - 16'd1;
          end
        end
      end
      S_WAIT: begin
        if (rise_tick) begin
          if (!i_cmd_in) begin
            state_d = S_RECV;
            rx_d    = rx_new[46:0];
            cnt_d   = 16'd1;
          end else if (cnt_q == NCR_LAST) begin
            state_d = S_POST;
            to_d    = 1'b1;
            cnt_d   = 16'd0;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      S_RECV: begin
        if (rise_tick) begin
          rx_d = rx_new[46:0];
          if (cnt_q == 16'd47) begin
            state_d    = S_POST;
            cnt_d      = 16'd0;
            resp_idx_d = rx_new[45:40];
            resp_arg_d = rx_new[39:8];
            crc_err_d  = (crc7(rx_new[47:8]) != rx_new[7:1]) && !ign_crc_q;
            end_err_d  = !rx_new[0];
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      S_POST: begin
        if (rise_tick) begin
          if (cnt_q == 16'd7) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            cnt_d   = 16'd0;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Reads see pre-update state, so a STATUS read racing done returns the old value.
  always_comb begin
    rmux = 32'd0;
    case (i_address)
      3'd0: rmux = arg_q;
      3'd1: rmux = {27'd0, end_err_q, crc_err_q, to_q, done_q, busy};
      3'd2: rmux = resp_arg_q;
      3'd3: rmux = {26'd0, resp_idx_q};
      3'd4: rmux = {15'd0, free_q, div_q};
      default: rmux = 32'd0;
    endcase
    rdata_d = rd ? rmux : 32'd0;
    ready_d = i_request;
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q    <= S_IDLE;
      sh_q       <= '1;
      rx_q       <= '0;
      cnt_q      <= '0;
      arg_q      <= '0;
      div_q      <= DIV_RST;
      free_q     <= 1'b0;
      resp_arg_q <= '0;
      resp_idx_q <= '0;
      done_q     <= 1'b0;
      to_q       <= 1'b0;
      crc_err_q  <= 1'b0;
      end_err_q  <= 1'b0;
      resp_en_q  <= 1'b0;
      ign_crc_q  <= 1'b0;
      clk_cnt_q  <= '0;
      sd_clk_q   <= 1'b0;
      ready_q    <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      sh_q       <= sh_d;
      rx_q       <= rx_d;
      cnt_q      <= cnt_d;
      arg_q      <= arg_d;
      div_q      <= div_d;
      free_q     <= free_d;
      resp_arg_q <= resp_arg_d;
      resp_idx_q <= resp_idx_d;
      done_q     <= done_d;
      to_q       <= to_d;
      crc_err_q  <= crc_err_d;
      end_err_q  <= end_err_d;
      resp_en_q  <= resp_en_d;
      ign_crc_q  <= ign_crc_d;
      clk_cnt_q  <= clk_cnt_d;
      sd_clk_q   <= sd_clk_d;
      ready_q    <= ready_d;
      rdata_q    <= rdata_d;
    end
  end

  assign o_rdata   = rdata_q;
  assign o_ready   = ready_q;
  assign o_sd_clk  = sd_clk_q;
  assign o_cmd_oe  = (state_q == S_SEND);
  assign o_cmd_out = (state_q == S_SEND) ? sh_q[47] : 1'b1;

endmodule
